// File: rtl/decode_stage_pipe_pkg.sv
// Beta ISA constants and opcode-class decode shared by the decode stage.
package beta_pkg;

  localparam logic [5:0] OPC_LD  = 6'h18;
  localparam logic [5:0] OPC_ST  = 6'h19;
  localparam logic [5:0] OPC_JMP = 6'h1B;
  localparam logic [5:0] OPC_BEQ = 6'h1C;
  localparam logic [5:0] OPC_BNE = 6'h1D;
  localparam logic [5:0] OPC_LDR = 6'h1F;

  localparam logic [31:0] INST_NOP        = 32'h83FF_F800;
  localparam logic [31:0] INST_BNE_EXCEPT = 32'h77DF_0000;

  typedef enum logic [3:0] {
    CLS_OP,
    CLS_OPC,
    CLS_LD,
    CLS_ST,
    CLS_JMP,
    CLS_BEQ,
    CLS_BNE,
    CLS_LDR,
    CLS_ILL
  } op_class_e;

  function automatic op_class_e op_class(input logic [5:0] opcode);
    op_class_e cls;
    case (opcode[5:4])
      2'b10:   cls = CLS_OP;
      2'b11:   cls = CLS_OPC;
      default: begin
        case (opcode)
          OPC_LD:  cls = CLS_LD;
          OPC_ST:  cls = CLS_ST;
          OPC_JMP: cls = CLS_JMP;
          OPC_BEQ: cls = CLS_BEQ;
          OPC_BNE: cls = CLS_BNE;
          OPC_LDR: cls = CLS_LDR;
          default: cls = CLS_ILL;
        endcase
      end
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/decode_stage_pipe_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage, plus the fetch redirect.
interface decode_stage_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_ir;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_ir;
  logic [XLEN-1:0] out_a;
  logic [XLEN-1:0] out_b;
  logic [XLEN-1:0] out_d;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output in_valid, in_pc, in_ir, out_ready,
    input  in_ready, out_valid, out_pc, out_ir, out_a, out_b, out_d, redirect, redirect_pc
  );

  modport slave (
    input  in_valid, in_pc, in_ir, out_ready,
    output in_ready, out_valid, out_pc, out_ir, out_a, out_b, out_d, redirect, redirect_pc
  );
endinterface

// File: rtl/decode_stage_pipe_reg_file_byp.sv
// 2-read/1-write register file with write-through and a nearest-first bypass network.
module reg_file_byp
  import beta_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NBYP = 3,
  parameter int AW   = 5
) (
  input  logic                 clk,
  input  logic                 rf_we,
  input  logic [AW-1:0]        rf_wa,
  input  logic [XLEN-1:0]      rf_wd,
  input  logic [AW-1:0]        ra1,
  input  logic [AW-1:0]        ra2,
  input  logic [NBYP-1:0]      byp_valid,
  input  logic [NBYP*AW-1:0]   byp_addr,
  input  logic [NBYP*XLEN-1:0] byp_data,
  output logic [XLEN-1:0]      rd1,
  output logic [XLEN-1:0]      rd2
);
  localparam logic [AW-1:0] ZR_ADDR = AW'(NREG - 1);

  logic [XLEN-1:0] regs_r [NREG];

  // The zero register is never stored; everything else is plain storage without reset.
  always_ff @(posedge clk) begin
    if (rf_we && (rf_wa != ZR_ADDR)) begin
      regs_r[rf_wa] <= rf_wd;
    end
  end

  // Walk bypasses farthest-to-nearest so the nearest matching source overrides the rest.
  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
    logic [XLEN-1:0] val;
    val = (rf_we && (rf_wa == addr)) ? rf_wd : regs_r[addr];
    for (int i = NBYP - 1; i >= 0; i--) begin
      val = (byp_valid[i] && (byp_addr[i*AW +: AW] == addr)) ? byp_data[i*XLEN +: XLEN] : val;
    end
    val = (addr == ZR_ADDR) ? '0 : val;
    return val;
  endfunction

  // Both read ports share the same priority mux.
  always_comb begin
    rd1 = read_port(ra1);
    rd2 = read_port(ra2);
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// Beta decode stage: pipeline register, operand sourcing, load-use interlock,
// early branch/jump resolution, flush and exception injection.
module decode_stage_pipe
  import beta_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NBYP = 3,
  parameter int AW   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  decode_stage_pipe_if.slave   bus,
  input  logic                 flush,
  input  logic                 exc_req,
  input  logic [NBYP-1:0]      byp_valid,
  input  logic [NBYP*AW-1:0]   byp_addr,
  input  logic [NBYP*XLEN-1:0] byp_data,
  input  logic                 ex_is_load,
  input  logic                 rf_we,
  input  logic [AW-1:0]        rf_wa,
  input  logic [XLEN-1:0]      rf_wd
);
  localparam logic [AW-1:0] ZR_ADDR = AW'(NREG - 1);

  logic            dec_valid_r;
  logic [31:0]     dec_ir_r;
  logic [XLEN-1:0] dec_pc_r;
  logic            exc_pend_r;

  logic [5:0]      opcode_s;
  logic [AW-1:0]   rc_s;
  logic [AW-1:0]   ra_s;
  logic [AW-1:0]   rb_s;
  logic [AW-1:0]   ra2_s;
  logic [15:0]     c_s;
  op_class_e       cls_s;
  logic [XLEN-1:0] rd1_s;
  logic [XLEN-1:0] rd2_s;
  logic [XLEN-1:0] sxt_s;
  logic [XLEN-1:0] br_tgt_s;
  logic [XLEN-1:0] jmp_tgt_s;
  logic [XLEN-1:0] tgt_s;
  logic            zr_s;
  logic            taken_s;
  logic            use_ra_s;
  logic            use_rb_s;
  logic            use_rc_s;
  logic [AW-1:0]   byp0_addr_s;
  logic            hit_s;
  logic            hazard_s;
  logic            exc_act_s;
  logic            out_valid_s;
  logic            fire_s;
  logic            consume_s;
  logic            in_ready_s;
  logic            load_s;
  logic            redirect_s;
  logic [31:0]     out_ir_s;

  assign opcode_s = dec_ir_r[31:26];
  assign rc_s     = AW'(dec_ir_r[25:21]);
  assign ra_s     = AW'(dec_ir_r[20:16]);
  assign rb_s     = AW'(dec_ir_r[15:11]);
  assign c_s      = dec_ir_r[15:0];
  assign cls_s    = op_class(opcode_s);
  // Stores read their data register through port 2.
  assign ra2_s    = (cls_s == CLS_ST) ? rc_s : rb_s;

  reg_file_byp #(
    .XLEN (XLEN),
    .NREG (NREG),
    .NBYP (NBYP),
    .AW   (AW)
  ) u_rf (
    .clk       (clk),
    .rf_we     (rf_we),
    .rf_wa     (rf_wa),
    .rf_wd     (rf_wd),
    .ra1       (ra_s),
    .ra2       (ra2_s),
    .byp_valid (byp_valid),
    .byp_addr  (byp_addr),
    .byp_data  (byp_data),
    .rd1       (rd1_s),
    .rd2       (rd2_s)
  );

  assign sxt_s     = {{(XLEN-16){c_s[15]}}, c_s};
  assign br_tgt_s  = dec_pc_r + {sxt_s[XLEN-3:0], 2'b00};
  // JMP may only keep the supervisor bit if the jumping code already had it.
  assign jmp_tgt_s = {rd1_s[XLEN-1] & dec_pc_r[XLEN-1], rd1_s[XLEN-2:2], 2'b00};
  assign zr_s      = (rd1_s == '0);

  // Registers each class genuinely reads; LDR addresses memory PC-relative only.
  always_comb begin
    use_ra_s = 1'b0;
    use_rb_s = 1'b0;
    use_rc_s = 1'b0;
    case (cls_s)
      CLS_OP: begin
        use_ra_s = 1'b1;
        use_rb_s = 1'b1;
      end
      CLS_OPC, CLS_LD, CLS_JMP, CLS_BEQ, CLS_BNE: use_ra_s = 1'b1;
      CLS_ST: begin
        use_ra_s = 1'b1;
        use_rc_s = 1'b1;
      end
      default: use_ra_s = 1'b0;
    endcase
  end

  // Branch decision and target select.
  always_comb begin
    taken_s = 1'b0;
    tgt_s   = br_tgt_s;
    case (cls_s)
      CLS_JMP: begin
        taken_s = 1'b1;
        tgt_s   = jmp_tgt_s;
      end
      CLS_BEQ: taken_s = zr_s;
      CLS_BNE: taken_s = ~zr_s;
      default: taken_s = 1'b0;
    endcase
  end

  assign byp0_addr_s = byp_addr[AW-1:0];
  assign hit_s       = (byp0_addr_s != ZR_ADDR) &&
                       ((use_ra_s && (byp0_addr_s == ra_s)) ||
                        (use_rb_s && (byp0_addr_s == rb_s)) ||
                        (use_rc_s && (byp0_addr_s == rc_s)));
  assign hazard_s    = dec_valid_r & ex_is_load & byp_valid[0] & hit_s;
  assign exc_act_s   = exc_req | exc_pend_r;
  assign out_valid_s = dec_valid_r & ~flush & ~rst;
  assign fire_s      = out_valid_s & bus.out_ready;
  // An exception issue consumes the instruction even under a load-use hazard.
  assign consume_s   = fire_s & (~hazard_s | exc_act_s);
  assign in_ready_s  = rst | flush | ~dec_valid_r | consume_s;
  assign load_s      = bus.in_valid & in_ready_s;
  assign redirect_s  = consume_s & ~exc_act_s & taken_s;

  // Issued instruction word: exception beats interlock bubble beats the decoded word.
  always_comb begin
    if (rst) begin
      out_ir_s = INST_NOP;
    end else if (exc_act_s) begin
      out_ir_s = INST_BNE_EXCEPT;
    end else if (hazard_s) begin
      out_ir_s = INST_NOP;
    end else begin
      out_ir_s = dec_ir_r;
    end
  end

  // Decode pipeline register and the pending-exception flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_valid_r <= 1'b0;
      dec_ir_r    <= INST_NOP;
      dec_pc_r    <= '0;
      exc_pend_r  <= 1'b0;
    end else begin
      if (load_s) begin
        dec_valid_r <= 1'b1;
        dec_ir_r    <= bus.in_ir;
        dec_pc_r    <= bus.in_pc;
      end else if (flush || consume_s) begin
        dec_valid_r <= 1'b0;
      end
      if (fire_s && exc_act_s) begin
        exc_pend_r <= 1'b0;
      end else if (exc_req) begin
        exc_pend_r <= 1'b1;
      end
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = out_valid_s;
  assign bus.out_pc      = dec_pc_r;
  assign bus.out_ir      = out_ir_s;
  assign bus.out_a       = (cls_s == CLS_LDR) ? br_tgt_s : rd1_s;
  assign bus.out_b       = ((cls_s == CLS_LD) || (cls_s == CLS_ST) || (cls_s == CLS_OPC)) ? sxt_s : rd2_s;
  assign bus.out_d       = rd2_s;
  assign bus.redirect    = redirect_s;
  assign bus.redirect_pc = tgt_s;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Randomized bench for decode_stage_pipe against a queue-based reference model, plus directed scenarios.
module tb_decode_stage_pipe;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NBYP = 3;
  localparam int AW   = 5;
  localparam logic [31:0] NOP = 32'h83FF_F800;
  localparam logic [31:0] EXC = 32'h77DF_0000;

  logic clk;
  logic rst;
  logic flush;
  logic exc_req;
  logic ex_is_load;
  logic rf_we;
  logic [AW-1:0] rf_wa;
  logic [XLEN-1:0] rf_wd;
  logic [NBYP-1:0] byp_valid;
  logic [NBYP*AW-1:0] byp_addr;
  logic [NBYP*XLEN-1:0] byp_data;

  int checks = 0;
  int failures = 0;

  decode_stage_pipe_if #(.XLEN(XLEN)) bus ();

  decode_stage_pipe #(.XLEN(XLEN), .NREG(NREG), .NBYP(NBYP), .AW(AW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .flush(flush), .exc_req(exc_req),
    .byp_valid(byp_valid), .byp_addr(byp_addr), .byp_data(byp_data),
    .ex_is_load(ex_is_load), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] ir; logic [31:0] pc; } slot_t;
  slot_t held[$];
  bit xpend_m = 1'b0;
  logic [31:0] rf_m [NREG];

  function automatic bit reads_reg(input logic [31:0] ir, input int r);
    int op = int'(ir[31:26]);
    int rc = int'(ir[25:21]);
    int ra = int'(ir[20:16]);
    int rb = int'(ir[15:11]);
    if (r == NREG - 1) return 1'b0;
    if (op >= 32 && op < 48) return (r == ra) || (r == rb);
    if (op >= 48) return r == ra;
    if (op == 'h18 || op == 'h1B || op == 'h1C || op == 'h1D) return r == ra;
    if (op == 'h19) return (r == ra) || (r == rc);
    return 1'b0;
  endfunction

  function automatic logic [31:0] operand(input int addr);
    if (addr == NREG - 1) return 32'd0;
    for (int i = 0; i < NBYP; i++)
      if (byp_valid[i] && int'(byp_addr[i*AW +: AW]) == addr) return byp_data[i*XLEN +: XLEN];
    if (rf_we && int'(rf_wa) == addr) return rf_wd;
    return rf_m[addr];
  endfunction

  // Compare DUT against the model every cycle, then advance the model across the coming edge.
  always @(negedge clk) begin : cmp
    logic [31:0] ir, pc, rd1, rd2, sxt, bt, jt, eir, et;
    bit hv, exc, hz, ov, fire, consume, inr, taken, redir;
    int op, a2;
    if (rst) begin
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_redirect", bus.redirect, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_ir", bus.out_ir, NOP);
      held.delete();
      xpend_m = 1'b0;
    end else begin
      hv = held.size() != 0;
      ir = hv ? held[0].ir : NOP;
      pc = hv ? held[0].pc : 32'd0;
      op = int'(ir[31:26]);
      exc = exc_req || xpend_m;
      hz = hv && ex_is_load && byp_valid[0] && reads_reg(ir, int'(byp_addr[AW-1:0]));
      ov = hv && !flush;
      fire = ov && bus.out_ready;
      consume = fire && (!hz || exc);
      inr = flush || !hv || consume;
      eir = exc ? EXC : (hz ? NOP : ir);
      rd1 = operand(int'(ir[20:16]));
      a2 = (op == 'h19) ? int'(ir[25:21]) : int'(ir[15:11]);
      rd2 = operand(a2);
      sxt = {{16{ir[15]}}, ir[15:0]};
      bt = pc + sxt * 32'd4;
      jt = {rd1[31] & pc[31], rd1[30:2], 2'b00};
      taken = (op == 'h1B) || (op == 'h1C && rd1 == 0) || (op == 'h1D && rd1 != 0);
      et = (op == 'h1B) ? jt : bt;
      redir = consume && !exc && taken;
      chk("in_ready", bus.in_ready, inr);
      chk("out_valid", bus.out_valid, ov);
      chk("redirect", bus.redirect, redir);
      if (ov) begin
        chk("out_ir", bus.out_ir, eir);
        chk("out_pc", bus.out_pc, pc);
        if (!exc && !hz) begin
          chk("out_a", bus.out_a, (op == 'h1F) ? bt : rd1);
          chk("out_b", bus.out_b, (op == 'h18 || op == 'h19 || op >= 48) ? sxt : rd2);
          chk("out_d", bus.out_d, rd2);
        end
      end
      if (redir) chk("redirect_pc", bus.redirect_pc, et);
      if (fire && exc) xpend_m = 1'b0;
      else if (exc_req) xpend_m = 1'b1;
      if (bus.in_valid && inr) begin
        held.delete();
        held.push_back('{bus.in_ir, bus.in_pc});
      end else if (flush || consume) begin
        held.delete();
      end
    end
    if (rf_we && int'(rf_wa) != NREG - 1) rf_m[rf_wa] = rf_wd;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0; bus.in_pc = 32'd0; bus.in_ir = NOP; bus.out_ready = 1'b1;
    flush = 1'b0; exc_req = 1'b0; ex_is_load = 1'b0;
    rf_we = 1'b0; rf_wa = '0; rf_wd = '0;
    byp_valid = '0; byp_addr = '0; byp_data = '0;
  endtask

  task automatic set_byp(input int i, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    byp_valid[i] = 1'b1;
    byp_addr[i*AW +: AW] = a;
    byp_data[i*XLEN +: XLEN] = d;
  endtask

  task automatic issue(input logic [31:0] ir, input logic [31:0] pc);
    bus.in_valid = 1'b1; bus.in_ir = ir; bus.in_pc = pc;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic rf_write(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    rf_we = 1'b1; rf_wa = a; rf_wd = d;
    tick();
    rf_we = 1'b0;
  endtask

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rc,
                                      input logic [4:0] ra, input logic [15:0] c);
    return {op, rc, ra, c};
  endfunction

  function automatic logic [4:0] rsel();
    return ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] rand_ir();
    logic [5:0] op;
    logic [4:0] ra;
    case ($urandom_range(0, 9))
      0: op = 6'h20;
      1: op = 6'h21;
      2: op = 6'h24;
      3: op = 6'h30;
      4: op = 6'h18;
      5: op = 6'h19;
      6: op = 6'h1B;
      7: op = 6'h1C;
      8: op = 6'h1D;
      default: op = 6'h1F;
    endcase
    ra = (op == 6'h1F) ? 5'd31 : rsel();
    return enc(op, rsel(), ra, {rsel(), 11'($urandom)});
  endfunction

  function automatic logic [31:0] rdata();
    return ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
  endfunction

  logic [31:0] add123, add546, sub823, beq7;

  initial begin
    add123 = enc(6'h20, 5'd1, 5'd2, {5'd3, 11'd0});
    add546 = enc(6'h20, 5'd5, 5'd4, {5'd6, 11'd0});
    sub823 = enc(6'h21, 5'd8, 5'd2, {5'd3, 11'd0});
    beq7   = enc(6'h1C, 5'd0, 5'd7, 16'hFFFE);
    idle();
    rst = 1'b1;
    @(negedge clk);
    chk("t0_reset_in_ready", bus.in_ready, 1);
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t0_reset_pc", bus.out_pc, 0);
    chk("t0_reset_valid", bus.out_valid, 0);
    tick();
    for (int i = 0; i < NREG - 1; i++) rf_write(5'(i), 32'hA000_0000 + 32'(i));

    // plain ADD
    issue(add123, 32'h104);
    @(negedge clk);
    chk("t1_valid", bus.out_valid, 1);
    chk("t1_ir", bus.out_ir, add123);
    chk("t1_a", bus.out_a, 32'hA000_0002);
    chk("t1_b", bus.out_b, 32'hA000_0003);
    tick();

    // bypass priority and R31
    issue(add123, 32'h108);
    set_byp(0, 5'd2, 32'h11); set_byp(2, 5'd2, 32'h22);
    @(negedge clk);
    chk("t2_byp_near", bus.out_a, 32'h11);
    tick();
    byp_valid = '0;
    issue(enc(6'h20, 5'd1, 5'd31, {5'd3, 11'd0}), 32'h10C);
    set_byp(0, 5'd31, 32'h33);
    @(negedge clk);
    chk("t2_r31", bus.out_a, 32'h0);
    tick();
    byp_valid = '0;

    // load-use interlock
    issue(add546, 32'h110);
    bus.in_valid = 1'b1; bus.in_ir = add123; ex_is_load = 1'b1; set_byp(0, 5'd4, 32'h44);
    @(negedge clk);
    chk("t3_nop_valid", bus.out_valid, 1);
    chk("t3_nop_ir", bus.out_ir, NOP);
    chk("t3_in_ready", bus.in_ready, 0);
    tick();
    bus.in_valid = 1'b0; ex_is_load = 1'b0;
    @(negedge clk);
    chk("t3_ir", bus.out_ir, add546);
    chk("t3_a", bus.out_a, 32'h44);
    tick();
    byp_valid = '0;

    // early branch
    rf_write(5'd7, 32'd0);
    issue(beq7, 32'h100);
    @(negedge clk);
    chk("t4_redirect", bus.redirect, 1);
    chk("t4_target", bus.redirect_pc, 32'hF8);
    tick();
    @(negedge clk);
    chk("t4_one_shot", bus.redirect, 0);
    tick();
    rf_write(5'd7, 32'd5);
    issue(beq7, 32'h100);
    @(negedge clk);
    chk("t4_not_taken", bus.redirect, 0);
    tick();

    // backpressure
    rf_write(5'd7, 32'd0);
    issue(beq7, 32'h100);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5_hold_valid", bus.out_valid, 1);
      chk("t5_hold_in_ready", bus.in_ready, 0);
      chk("t5_hold_redirect", bus.redirect, 0);
      chk("t5_hold_pc", bus.out_pc, 32'h100);
      tick();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t5_fire_redirect", bus.redirect, 1);
    tick();

    // flush with a concurrent fetch
    bus.out_ready = 1'b0;
    issue(add123, 32'h300);
    flush = 1'b1; bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_ir = sub823; bus.in_pc = 32'h200;
    @(negedge clk);
    chk("t6_flush_valid", bus.out_valid, 0);
    chk("t6_flush_in_ready", bus.in_ready, 1);
    tick();
    flush = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t6_new_ir", bus.out_ir, sub823);
    chk("t6_new_pc", bus.out_pc, 32'h200);
    tick();

    // exception injection
    issue(add123, 32'h400);
    exc_req = 1'b1;
    @(negedge clk);
    chk("t6_exc_ir", bus.out_ir, EXC);
    chk("t6_exc_pc", bus.out_pc, 32'h400);
    tick();
    exc_req = 1'b0;
    @(negedge clk);
    chk("t6_exc_consumed", bus.out_valid, 0);
    tick();

    // reset during an interlock
    issue(add546, 32'h500);
    ex_is_load = 1'b1; set_byp(0, 5'd4, 32'h44);
    @(negedge clk);
    chk("t6_hz_nop", bus.out_ir, NOP);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_valid", bus.out_valid, 0);
    tick();
    idle();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.in_ir     = rand_ir();
      bus.in_pc     = {$urandom} & 32'hFFFF_FFFC;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 19) == 0);
      exc_req       = ($urandom_range(0, 24) == 0);
      ex_is_load    = ($urandom_range(0, 2) == 0);
      rst           = ($urandom_range(0, 199) == 0);
      rf_we         = ($urandom_range(0, 2) == 0);
      rf_wa         = rsel();
      rf_wd         = rdata();
      for (int i = 0; i < NBYP; i++) begin
        byp_valid[i] = ($urandom_range(0, 1) == 0);
        byp_addr[i*AW +: AW] = rsel();
        byp_data[i*XLEN +: XLEN] = rdata();
      end
      tick();
    end
    idle();
    rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
